// File: rtl/rr_bus_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter.
// Holds the state encoding and the fixed datapath dimensions.
package rr_bus_arbiter_4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

endpackage

// File: rtl/rr_bus_arbiter_4_mux.sv
// Existing 4-to-1 datapath multiplexer, reused unchanged by the arbiter.
import rr_bus_arbiter_4_pkg::*;

module mux_4_to_1 (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        out = in1;
        case (sel)
            2'd0:    out = in1;
            2'd1:    out = in2;
            2'd2:    out = in3;
            default: out = in4;
        endcase
    end

endmodule

// File: rtl/rr_bus_arbiter_4.sv
// Round-robin arbiter sharing one 32-bit datapath among four requesters,
// with a per-grant hold limit and a valid-gated muxed output.
module rr_bus_arbiter_4
    import rr_bus_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = $clog2(MAX_HOLD) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [DATA_W-1:0]   in1,
    input  logic [DATA_W-1:0]   in2,
    input  logic [DATA_W-1:0]   in3,
    input  logic [DATA_W-1:0]   in4,
    output logic [NUM_REQ-1:0]  grant,
    output logic [1:0]          sel,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                preempt
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              state_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [1:0]          last_ptr_reg;
    logic [NUM_REQ-1:0]  grant_reg;
    logic [1:0]          sel_reg;
    logic                preempt_reg;

    logic [2:0]          win;
    logic                win_found;
    logic [1:0]          win_idx;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [DATA_W-1:0]   mux_data;

    // Scan from the slot after last_ptr; descending loop so the nearest hit wins.
    function automatic logic [2:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                               input logic [1:0]         last);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign win       = pick_winner(req, last_ptr_reg);
    assign win_found = win[2];
    assign win_idx   = win[1:0];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign win_onehot[gi] = win_found && (win_idx == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            last_ptr_reg <= 2'd3;
            grant_reg    <= '0;
            sel_reg      <= '0;
            preempt_reg  <= 1'b0;
        end else begin
            preempt_reg <= 1'b0;
            case (state_reg)
                GRANT: begin
                    if (req[sel_reg] && hold_cnt_reg != HOLD_LAST) begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end else begin
                        // Owner still requesting here means the hold limit forced it out.
                        preempt_reg <= req[sel_reg];
                        if (win_found) begin
                            grant_reg    <= win_onehot;
                            sel_reg      <= win_idx;
                            last_ptr_reg <= win_idx;
                        end else begin
                            state_reg <= IDLE;
                            grant_reg <= '0;
                        end
                        hold_cnt_reg <= '0;
                    end
                end
                default: begin
                    if (win_found) begin
                        state_reg    <= GRANT;
                        grant_reg    <= win_onehot;
                        sel_reg      <= win_idx;
                        last_ptr_reg <= win_idx;
                        hold_cnt_reg <= '0;
                    end
                end
            endcase
        end
    end

    mux_4_to_1 u_mux (
        .sel (sel_reg),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .in4 (in4),
        .out (mux_data)
    );

    assign grant     = grant_reg;
    assign sel       = sel_reg;
    assign preempt   = preempt_reg;
    assign out_valid = |grant_reg;
    assign out_data  = out_valid ? mux_data : '0;

endmodule

// File: tb/tb_rr_bus_arbiter_4.sv
// Directed bench for rr_bus_arbiter_4: default hold limit plus a second
// instance with a one-cycle hold limit sharing the same stimulus.
module tb_rr_bus_arbiter_4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] in1, in2, in3, in4;

    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [31:0] out_data;
    logic        out_valid;
    logic        preempt;

    logic [3:0]  grant1;
    logic [1:0]  sel1;
    logic [31:0] out_data1;
    logic        out_valid1;
    logic        preempt1;

    int errors = 0;
    int checks = 0;

    rr_bus_arbiter_4 #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .grant(grant), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .preempt(preempt)
    );

    rr_bus_arbiter_4 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .grant(grant1), .sel(sel1), .out_data(out_data1),
        .out_valid(out_valid1), .preempt(preempt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++;
        if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
        checks++;
        if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b want 0", preempt); end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL reset_out: valid=%b data=%h want 0/0", out_valid, out_data);
        end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001 || sel !== 2'd0) begin
            errors++; $display("FAIL basic_grant: grant=%b sel=%0d want 0001/0", grant, sel);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
            errors++; $display("FAIL basic_data: valid=%b data=%h want 1/a5a50001", out_valid, out_data);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (grant !== 4'b0001 || preempt !== 1'b0) begin
            errors++; $display("FAIL basic_hold: grant=%b preempt=%b want 0001/0", grant, preempt);
        end
        $display("test_basic done");
    endtask

    task automatic test_rotation();
        logic [3:0] exp_grant;
        logic       exp_pre;
        int         owner;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k <= 40; k++) begin
            tick();
            owner     = (k / 8) % 4;
            exp_grant = 4'b0001 << owner;
            exp_pre   = (k > 0) && (k % 8 == 0);
            checks++;
            if (grant !== exp_grant || sel !== 2'(owner)) begin
                errors++; $display("FAIL rotation_grant k=%0d: grant=%b sel=%0d want %b/%0d", k, grant, sel, exp_grant, owner);
            end
            checks++;
            if (preempt !== exp_pre) begin
                errors++; $display("FAIL rotation_preempt k=%0d: got %b want %b", k, preempt, exp_pre);
            end
        end
        $display("test_rotation done");
    endtask

    task automatic test_release();
        do_reset();
        req = 4'b0101;
        tick();
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL release_first: grant=%b want 0001", grant); end
        tick();
        tick();
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100 || sel !== 2'd2) begin
            errors++; $display("FAIL release_switch: grant=%b sel=%0d want 0100/2", grant, sel);
        end
        checks++;
        if (preempt !== 1'b0) begin errors++; $display("FAIL release_preempt: got %b want 0", preempt); end
        checks++;
        if (out_data !== 32'hC3C3_0003) begin errors++; $display("FAIL release_data: got %h want c3c30003", out_data); end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL drop_all: grant=%b valid=%b data=%h want 0000/0/0", grant, out_valid, out_data);
        end
        checks++;
        if (sel !== 2'd2) begin errors++; $display("FAIL drop_sel: got %0d want 2", sel); end
        $display("test_release done");
    endtask

    task automatic test_single();
        logic exp_pre;
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_pre = (k == 8) || (k == 16);
            checks++;
            if (grant !== 4'b0010 || out_data !== 32'h5A5A_0002) begin
                errors++; $display("FAIL single_grant k=%0d: grant=%b data=%h want 0010/5a5a0002", k, grant, out_data);
            end
            checks++;
            if (preempt !== exp_pre) begin
                errors++; $display("FAIL single_preempt k=%0d: got %b want %b", k, preempt, exp_pre);
            end
        end
        $display("test_single done");
    endtask

    task automatic test_max_hold_one();
        logic [3:0] exp_grant;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_grant = 4'b0001 << (k % 4);
            checks++;
            if (grant1 !== exp_grant || sel1 !== 2'(k % 4)) begin
                errors++; $display("FAIL hold1_grant k=%0d: grant=%b sel=%0d want %b/%0d", k, grant1, sel1, exp_grant, k % 4);
            end
            checks++;
            if (preempt1 !== (k > 0)) begin
                errors++; $display("FAIL hold1_preempt k=%0d: got %b want %b", k, preempt1, k > 0);
            end
        end
        $display("test_max_hold_one done");
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0001;
        for (int k = 0; k <= 8; k++) tick();
        checks++;
        if (preempt !== 1'b1 || grant !== 4'b0001) begin
            errors++; $display("FAIL async_pre_state: preempt=%b grant=%b want 1/0001", preempt, grant);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || preempt !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: grant=%b preempt=%b valid=%b want 0000/0/0", grant, preempt, out_valid);
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1000;
        tick();
        checks++;
        if (grant !== 4'b1000 || sel !== 2'd3 || out_data !== 32'h3C3C_0004) begin
            errors++; $display("FAIL async_after: grant=%b sel=%0d data=%h want 1000/3/3c3c0004", grant, sel, out_data);
        end
        do_reset();
        req = 4'b1001;
        tick();
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL async_priority: grant=%b want 0001", grant); end
        req = 4'b0000;
        $display("test_async_reset done");
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        in1 = 32'hA5A5_0001;
        in2 = 32'h5A5A_0002;
        in3 = 32'hC3C3_0003;
        in4 = 32'h3C3C_0004;
        test_reset();
        test_basic();
        test_rotation();
        test_release();
        test_single();
        test_max_hold_one();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
